// File: rtl/cnn_mac_pkg.sv
// Shared constants and helpers for the pipelined fixed-point MAC.
// Default widths, product-width helper and the round/shift/saturate stage.
package cnn_mac_pkg;

  localparam int A_W_DEF        = 14;
  localparam int B_W_DEF        = 7;
  localparam int B_SIGNED_DEF   = 0;
  localparam int MUL_STAGES_DEF = 2;
  localparam int ACC_W_DEF      = 32;
  localparam int FRAC_SHIFT_DEF = 6;
  localparam int OUT_W_DEF      = 14;
  localparam int SAT_EN_DEF     = 1;

  // Wide enough for any legal accumulator plus its rounding constant.
  localparam int FIN_W = 64;

  typedef struct packed {
    logic [FIN_W-1:0] data;
    logic             ovf;
  } fin_t;

  // The weight is always widened by one bit, so signed*signed never overflows.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  // Round half-up, arithmetic shift, then clamp or wrap to out_w signed bits.
  function automatic fin_t round_sat(input logic signed [FIN_W-1:0] acc,
                                     input int frac_shift,
                                     input int out_w,
                                     input logic sat_en);
    logic signed [FIN_W-1:0] rnd;
    logic signed [FIN_W-1:0] r;
    logic signed [FIN_W-1:0] hi;
    logic signed [FIN_W-1:0] lo;
    logic signed [FIN_W-1:0] t;
    fin_t res;
    rnd = (frac_shift > 0) ? (64'sd1 <<< (frac_shift - 1)) : 64'sd0;
    r   = (acc + rnd) >>> frac_shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    t   = (r <<< (FIN_W - out_w)) >>> (FIN_W - out_w);
    res.data = r;
    res.ovf  = 1'b0;
    if (sat_en) begin
      if (r > hi) begin
        res.data = hi;
        res.ovf  = 1'b1;
      end else if (r < lo) begin
        res.data = lo;
        res.ovf  = 1'b1;
      end
    end else begin
      res.data = t;
      res.ovf  = (t != r);
    end
    return res;
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Operand extension, signed multiply and a MUL_STAGES-deep register chain
// carrying the product with its valid/first/last sideband.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int B_SIGNED   = B_SIGNED_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int ACC_W      = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [A_W-1:0]   in_a,
  input  logic        [B_W-1:0]   in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    m_valid,
  output logic                    m_first,
  output logic                    m_last,
  output logic signed [ACC_W-1:0] m_prod
);

  localparam int PW = prod_width(A_W, B_W);

  logic signed [B_W:0]  b_ext;
  logic signed [PW-1:0] mul;

  generate
    if (B_SIGNED != 0) begin : g_b_signed
      assign b_ext = $signed({in_b[B_W-1], in_b});
    end else begin : g_b_unsigned
      assign b_ext = $signed({1'b0, in_b});
    end
  endgenerate

  assign mul = PW'(in_a) * PW'(b_ext);

  logic signed [PW-1:0]   p_q [MUL_STAGES];
  logic [MUL_STAGES-1:0]  v_q;
  logic [MUL_STAGES-1:0]  f_q;
  logic [MUL_STAGES-1:0]  l_q;

  // en is the global advance: the whole chain moves or the whole chain holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        p_q[i] <= '0;
        v_q[i] <= 1'b0;
        f_q[i] <= 1'b0;
        l_q[i] <= 1'b0;
      end
    end else if (en) begin
      p_q[0] <= mul;
      v_q[0] <= in_valid;
      f_q[0] <= in_first;
      l_q[0] <= in_last;
      for (int i = 1; i < MUL_STAGES; i++) begin
        p_q[i] <= p_q[i-1];
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign m_valid = v_q[MUL_STAGES-1];
  assign m_first = f_q[MUL_STAGES-1];
  assign m_last  = l_q[MUL_STAGES-1];
  assign m_prod  = ACC_W'(p_q[MUL_STAGES-1]);

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined multiply-accumulate over first/last-delimited frames; each frame
// sum is rounded, shifted and saturated (or wrapped) onto a valid/ready output.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int B_SIGNED   = B_SIGNED_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SAT_EN     = SAT_EN_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic        [B_W-1:0]   in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_ovf
);

  generate
    if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
      $error("cnn_mac_pipe: MUL_STAGES must be in 1..4");
    end
    if (ACC_W < prod_width(A_W, B_W) || ACC_W > FIN_W - 1) begin : g_bad_acc
      $error("cnn_mac_pipe: ACC_W must hold the product and fit the finish stage");
    end
    if (FRAC_SHIFT < 0 || FRAC_SHIFT > ACC_W - 1) begin : g_bad_shift
      $error("cnn_mac_pipe: FRAC_SHIFT must be in 0..ACC_W-1");
    end
    if (OUT_W < 2 || OUT_W >= FIN_W) begin : g_bad_out
      $error("cnn_mac_pipe: OUT_W out of range");
    end
  endgenerate

  // Handshake: a beat moves when in_valid && in_ready; a result moves when
  // out_valid && out_ready. Every stage advances together only when the output
  // register is empty or being drained, so in_ready is that same advance.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic                    m_valid;
  logic                    m_first;
  logic                    m_last;
  logic signed [ACC_W-1:0] m_prod;

  cnn_mac_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .B_SIGNED   (B_SIGNED),
    .MUL_STAGES (MUL_STAGES),
    .ACC_W      (ACC_W)
  ) u_mul (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .en       (adv),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .m_valid  (m_valid),
    .m_first  (m_first),
    .m_last   (m_last),
    .m_prod   (m_prod)
  );

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    frame_closed;
  fin_t                    fin;
  logic                    unused_fin;

  // frame_closed lets a frame that forgot in_first still start from zero.
  always_comb begin
    acc_next = (m_first || frame_closed) ? m_prod : acc + m_prod;
    fin      = round_sat(FIN_W'(acc_next), FRAC_SHIFT, OUT_W, SAT_EN != 0);
  end

  assign unused_fin = ^fin.data[FIN_W-1:OUT_W];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc          <= '0;
      frame_closed <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ovf      <= 1'b0;
    end else if (adv) begin
      if (m_valid) begin
        acc          <= acc_next;
        frame_closed <= m_last;
      end
      if (m_valid && m_last) begin
        out_valid <= 1'b1;
        out_data  <= fin.data[OUT_W-1:0];
        out_ovf   <= fin.ovf;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Self-checking bench for cnn_mac_pipe: scenario tasks drive frames and push
// expected results; a monitor pops and compares on each output handshake.
module tb_cnn_mac_pipe;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_first;
  logic               in_last;
  logic               out_ready;
  logic signed [13:0] in_a;
  logic        [6:0]  in_b;

  logic               in_ready;
  logic               out_valid;
  logic signed [13:0] out_data;
  logic               out_ovf;

  logic               s_in_ready;
  logic               s_out_valid;
  logic signed [13:0] s_out_data;
  logic               s_out_ovf;

  logic [14:0] exp_q[$];
  logic [14:0] exp_s_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_s    = 0;
  bit          rnd_done = 0;

  cnn_mac_pipe dut (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  cnn_mac_pipe #(.B_SIGNED(1)) dut_s (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_ovf   (s_out_ovf)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: round half-up via floor division, then clamp to 14 signed bits.
  function automatic logic [14:0] model(input longint sum);
    longint t;
    longint r;
    logic [14:0] res;
    t = sum + 32;
    if (t >= 0) r = t / 64;
    else        r = -((-t + 63) / 64);
    if (r > 8191)       res = {1'b1, 14'h1FFF};
    else if (r < -8192) res = {1'b1, 14'h2000};
    else                res = {1'b0, r[13:0]};
    return res;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [14:0] e;
    #2;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got data=%0d ovf=%0b, none expected", out_data, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_ovf, out_data} !== e) begin
          n_fail++;
          $display("FAIL result: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                   out_data, out_ovf, $signed(e[13:0]), e[14]);
        end
      end
    end
    if (!rst && chk_s && s_out_valid && out_ready) begin
      n_checks++;
      if (exp_s_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_signed_result: got data=%0d", s_out_data);
      end else begin
        e = exp_s_q.pop_front();
        if ({s_out_ovf, s_out_data} !== e) begin
          n_fail++;
          $display("FAIL signed_b_result: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                   s_out_data, s_out_ovf, $signed(e[13:0]), e[14]);
        end
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_beat(input logic signed [13:0] a, input logic [6:0] b,
                           input logic f, input logic l, output int stalls);
    stalls   = 0;
    in_a     = a;
    in_b     = b;
    in_first = f;
    in_last  = l;
    in_valid = 1;
    #1;
    while (!in_ready && stalls < 300) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, stalls);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    in_first = 0;
    in_last  = 0;
  endtask

  task automatic send_frame(input int n, input logic signed [13:0] a, input logic [6:0] b,
                            input bit with_first, output int stalls);
    longint sum = 0;
    int     st;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      sum += longint'(a) * longint'(b);
      if (i == n - 1) exp_q.push_back(model(sum));
      send_beat(a, b, with_first && (i == 0), i == n - 1, st);
      stalls += st;
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((exp_q.size() > 0 || exp_s_q.size() > 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (exp_q.size() + exp_s_q.size() !== 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", tag,
               exp_q.size() + exp_s_q.size());
      exp_q.delete();
      exp_s_q.delete();
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1; in_valid = 0; in_first = 0; in_last = 0; in_a = 0; in_b = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    if (out_data !== 14'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %0b, required 0", out_ovf); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single_latency();
    int st;
    int cycles;
    out_ready = 1;
    exp_q.push_back(model(100 * 64));
    send_beat(100, 64, 1, 1, st);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (cycles !== 3) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required 3", cycles);
    end
    drain("single");
  endtask

  task automatic test_b_extension();
    int st;
    chk_s = 1;
    exp_q.push_back(model(-8192 * 127));
    exp_s_q.push_back({1'b0, 14'sd128});
    send_beat(-8192, 127, 1, 1, st);
    drain("b_ext");
    chk_s = 0;
  endtask

  task automatic test_back_to_back();
    int st1;
    int st2;
    send_frame(4, 64, 1, 1, st1);
    send_frame(2, -64, 1, 1, st2);
    n_checks++;
    if (st1 + st2 !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_in_ready: got %0d stall cycles, required 0", st1 + st2);
    end
    drain("b2b");
  endtask

  task automatic test_rounding();
    int st;
    logic signed [13:0] av[3] = '{14'sd1, -14'sd1, -14'sd3};
    for (int i = 0; i < 3; i++) send_frame(1, av[i], 32, 1, st);
    drain("round");
  endtask

  task automatic test_missing_first();
    int st;
    send_frame(1, 7, 64, 1, st);
    send_frame(2, 64, 1, 0, st);
    drain("missing_first");
  endtask

  task automatic test_backpressure();
    int st;
    out_ready = 0;
    for (int v = 5; v <= 7; v++) send_frame(1, 14'(v), 64, 1, st);
    repeat (5) begin
      @(negedge clk);
      #1;
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %0b, required 1", out_valid); end
      if (out_data !== 14'sd5) begin n_fail++; $display("FAIL bp_hold_data: got %0d, required 5", out_data); end
    end
    @(negedge clk);
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_consecutive: out_valid=%0b at release cycle %0d, required 1", out_valid, k + 1);
      end
    end
    @(negedge clk);
    drain("bp");
  endtask

  task automatic test_reset_midframe();
    int st;
    out_ready = 0;
    send_beat(9, 64, 1, 1, st);
    send_beat(1000, 64, 1, 0, st);
    send_beat(1000, 64, 0, 0, st);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %0b, required 1", out_valid); end
    #2;
    rst = 1;
    #1;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %0b, required 0", out_valid); end
    if (out_data !== 14'sd0) begin n_fail++; $display("FAIL async_reset_data: got %0d, required 0", out_data); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %0b, required 1", in_ready); end
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    exp_q.push_back(model(10 * 64));
    send_beat(10, 64, 0, 1, st);
    drain("after_reset");
  endtask

  task automatic test_random();
    int st;
    rnd_done = 0;
    fork
      begin
        for (int f = 0; f < 16; f++) begin
          int     n = $urandom_range(1, 4);
          longint sum = 0;
          for (int i = 0; i < n; i++) begin
            logic signed [13:0] a = 14'($urandom_range(0, 16383));
            logic        [6:0]  b = 7'($urandom_range(0, 127));
            sum += longint'(a) * longint'(b);
            if (i == n - 1) exp_q.push_back(model(sum));
            send_beat(a, b, i == 0, i == n - 1, st);
          end
        end
        rnd_done = 1;
      end
      begin
        int c = 0;
        while (!rnd_done && c < 5000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          c++;
        end
        out_ready = 1;
      end
    join
    out_ready = 1;
    drain("random");
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_b_extension();
    test_back_to_back();
    test_rounding();
    test_missing_first();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
